if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: stall  input  1  hazard-unit hold; PC and IF/ID register keep their values.
REQ-004 SHALL have port: flush  input  1  taken branch/jump resolved downstream; redirect PC and squash IF/ID.
REQ-005 SHALL have port: branch_target  input  32  redirect address, used only when flush=1.
REQ-006 SHALL have port: imem_addr  output  32  instruction memory address, equal to current PC (combinational).
REQ-007 SHALL have port: imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle.
REQ-008 SHALL have port: PC_out  output  32  PC of instruction held in IF/ID.
REQ-009 SHALL have port: instr_out  output  32  instruction held in IF/ID.
REQ-010 SHALL have port: valid_out  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-011 SHALL have port: halted  output  1  fetch FSM is in HALT.
REQ-012 SHALL have ports (PERF_CNT_EN only): stall_cnt  output  32 and flush_cnt  output  32  event counters.

Function
REQ-013 SHALL hold an internal 32-bit PC register; imem_addr SHALL equal PC at all times.
REQ-014 SHALL implement FSM states RUN and HALT; after reset, state = RUN.
REQ-015 Update priority per rising edge SHALL be: flush > stall > HALT > normal fetch.
REQ-016 Flush (any state): PC <= branch_target; instr_out <= 32'h00000013 (NOP); PC_out <= 0; valid_out <= 0; state <= RUN.
REQ-017 Stall without flush: PC, PC_out, instr_out, valid_out, state SHALL hold.
REQ-018 Normal fetch in RUN: PC <= PC + 4 (mod 2^32, wrap 0xFFFFFFFC -> 0); PC_out <= PC; instr_out <= imem_rdata; valid_out <= 1.
REQ-019 If the word latched in REQ-018 equals 32'h00000073 (ecall), state SHALL become HALT on the same edge and PC SHALL NOT advance (stays at ecall address).
REQ-020 In HALT without flush or stall: PC holds; IF/ID loads NOP with valid_out=0, PC_out=0.
REQ-021 halted SHALL be 1 exactly when state = HALT.
REQ-022 Fetch-to-IF/ID latency SHALL be one cycle; flush-to-first-target-instruction-in-IF/ID latency SHALL be two edges (redirect edge, fetch edge).
REQ-023 branch_target bits [1:0] SHALL be taken as given; no alignment check.

Reset
REQ-024 rst=0 SHALL immediately, independent of clk, set PC=0, PC_out=0, instr_out=32'h00000013, valid_out=0, state=RUN, halted=0, and counters=0.
REQ-025 Reset asserted mid-stall or mid-HALT SHALL discard all state; first fetch after release SHALL be from address 0.

Configuration
REQ-026 Macro PERF_CNT_EN SHALL compile in stall_cnt and flush_cnt; absent, the ports and counters SHALL not exist and behaviour SHALL be otherwise identical.
REQ-027 With PERF_CNT_EN: stall_cnt +1 on each edge with stall=1 and flush=0; flush_cnt +1 on each edge with flush=1; both wrap at 2^32; flush+stall together counts only flush.

Verification
REQ-028 Reset release, imem returns 0x00500093 at 0, 0x00A00113 at 4, no stall/flush -> after edge 1: PC_out=0, instr_out=0x00500093, valid=1, imem_addr=4; after edge 2: PC_out=4, instr_out=0x00A00113.
REQ-029 stall=1 for 2 edges at PC=8 -> PC, PC_out, instr_out unchanged for both; stall_cnt=2 (PERF_CNT_EN).
REQ-030 flush=1, stall=1, branch_target=0x40 at PC=0x10 -> next: imem_addr=0x40, instr_out=0x00000013, valid=0; next edge: PC_out=0x40, valid=1; flush_cnt=1, stall_cnt=0.
REQ-031 0x00000073 fetched at 0x20 -> instr_out=0x73, PC_out=0x20, halted=1, imem_addr stays 0x20; following edges valid=0; flush with target 0x100 -> halted=0, imem_addr=0x100.
REQ-032 PC forced to 0xFFFFFFFC via flush, then one normal edge -> imem_addr=0x00000000, PC_out=0xFFFFFFFC.
REQ-033 rst pulsed low between clock edges while in HALT -> outputs at reset values immediately, halted=0; after release first edge latches address 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALT fetch FSM.
// Optional macro PERF_CNT_EN adds stall_cnt / flush_cnt event counters.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | fetching: PC advances by 4, IF/ID loads the fetched word
// HALT  | ecall seen: PC frozen on the ecall, IF/ID fed with bubbles
module if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
`ifdef PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        halted
);

  localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        fetch_ecall;

  assign imem_addr   = pc_q;
  assign fetch_ecall = (imem_rdata == INSTR_ECALL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)                                 state_d = RUN;
    else if (!stall && state_q == RUN && fetch_ecall) state_d = HALT;
  end

  always_comb begin
    halted = (state_q == HALT);
  end

  // Priority: flush > stall > HALT bubble > normal fetch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= 32'h0;
      PC_out    <= 32'h0;
      instr_out <= INSTR_NOP;
      valid_out <= 1'b0;
    end else if (flush) begin
      pc_q      <= branch_target;
      PC_out    <= 32'h0;
      instr_out <= INSTR_NOP;
      valid_out <= 1'b0;
    end else if (!stall) begin
      if (state_q == HALT) begin
        PC_out    <= 32'h0;
        instr_out <= INSTR_NOP;
        valid_out <= 1'b0;
      end else begin
        PC_out    <= pc_q;
        instr_out <= imem_rdata;
        valid_out <= 1'b1;
        // ecall parks the PC on its own address
        if (!fetch_ecall) pc_q <= pc_q + 32'd4;
      end
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else if (flush) begin
      flush_cnt <= flush_cnt + 32'd1;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; counter checks compile in with PERF_CNT_EN.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic        halted;
`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  logic [31:0] mem [0:255];
  int checks = 0;
  int failures = 0;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .PC_out        (PC_out),
    .instr_out     (instr_out),
    .valid_out     (valid_out),
`ifdef PERF_CNT_EN
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt),
`endif
    .halted        (halted)
  );

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[9:2]];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] addr, input logic [31:0] pco,
                          input logic [31:0] ins, input logic vld, input logic hlt);
    chk({tag, ".imem_addr"}, imem_addr, addr);
    chk({tag, ".PC_out"}, PC_out, pco);
    chk({tag, ".instr_out"}, instr_out, ins);
    chk({tag, ".valid_out"}, {31'h0, valid_out}, {31'h0, vld});
    chk({tag, ".halted"}, {31'h0, halted}, {31'h0, hlt});
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] sc, input logic [31:0] fc);
`ifdef PERF_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, sc);
    chk({tag, ".flush_cnt"}, flush_cnt, fc);
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    mem[8] = 32'h0000_0073;

    rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = 32'h0;
    #12;
    chk_ifid("reset", 32'h0, 32'h0, 32'h13, 1'b0, 1'b0);
    chk_cnt("reset", 32'h0, 32'h0);
    rst = 1'b1;

    step(); chk_ifid("fetch0", 32'h4, 32'h0, 32'h0050_0093, 1'b1, 1'b0);
    step(); chk_ifid("fetch4", 32'h8, 32'h4, 32'h00A0_0113, 1'b1, 1'b0);

    stall = 1'b1;
    step(); chk_ifid("stall1", 32'h8, 32'h4, 32'h00A0_0113, 1'b1, 1'b0);
    step(); chk_ifid("stall2", 32'h8, 32'h4, 32'h00A0_0113, 1'b1, 1'b0);
    chk_cnt("stall2", 32'd2, 32'd0);
    stall = 1'b0;
    step(); chk_ifid("fetch8", 32'hC, 32'h8, 32'h1000_0002, 1'b1, 1'b0);
    step(); chk_ifid("fetchC", 32'h10, 32'hC, 32'h1000_0003, 1'b1, 1'b0);

    flush = 1'b1; stall = 1'b1; branch_target = 32'h40;
    step(); chk_ifid("flush_stall", 32'h40, 32'h0, 32'h13, 1'b0, 1'b0);
    chk_cnt("flush_stall", 32'd2, 32'd1);
    flush = 1'b0; stall = 1'b0;
    step(); chk_ifid("target40", 32'h44, 32'h40, 32'h1000_0010, 1'b1, 1'b0);

    flush = 1'b1; branch_target = 32'h1C;
    step(); chk_ifid("redir1C", 32'h1C, 32'h0, 32'h13, 1'b0, 1'b0);
    flush = 1'b0;
    step(); chk_ifid("fetch1C", 32'h20, 32'h1C, 32'h1000_0007, 1'b1, 1'b0);
    step(); chk_ifid("ecall", 32'h20, 32'h20, 32'h73, 1'b1, 1'b1);
    step(); chk_ifid("halt_bubble", 32'h20, 32'h0, 32'h13, 1'b0, 1'b1);
    stall = 1'b1;
    step(); chk_ifid("halt_stall", 32'h20, 32'h0, 32'h13, 1'b0, 1'b1);
    stall = 1'b0;
    step(); chk_ifid("halt_bubble2", 32'h20, 32'h0, 32'h13, 1'b0, 1'b1);
    chk_cnt("halt", 32'd3, 32'd2);

    flush = 1'b1; branch_target = 32'h100;
    step(); chk_ifid("unhalt", 32'h100, 32'h0, 32'h13, 1'b0, 1'b0);
    branch_target = 32'hFFFF_FFFC;
    step(); chk_ifid("redir_top", 32'hFFFF_FFFC, 32'h0, 32'h13, 1'b0, 1'b0);
    flush = 1'b0;
    step(); chk_ifid("wrap", 32'h0, 32'hFFFF_FFFC, 32'h1000_00FF, 1'b1, 1'b0);
    chk_cnt("wrap", 32'd3, 32'd4);

    flush = 1'b1; branch_target = 32'h20;
    step(); flush = 1'b0;
    step(); chk_ifid("ecall2", 32'h20, 32'h20, 32'h73, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1 chk_ifid("async_rst", 32'h0, 32'h0, 32'h13, 1'b0, 1'b0);
    chk_cnt("async_rst", 32'd0, 32'd0);
    #2 rst = 1'b1;
    step(); chk_ifid("post_rst", 32'h4, 32'h0, 32'h0050_0093, 1'b1, 1'b0);

    flush = 1'b1; branch_target = 32'h42;
    step(); chk_ifid("unaligned", 32'h42, 32'h0, 32'h13, 1'b0, 1'b0);
    flush = 1'b0;
    step(); chk_ifid("fetch42", 32'h46, 32'h42, 32'h1000_0010, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
